// File: rtl/bus_memory_controller.sv
// Memory-side bus endpoint: services one read/write packet at a time against an internal word RAM.
// Latency: writes and drops complete on the accept edge; a read response is sent READ_LATENCY+1 cycles after accept.
// Backpressure: the response is held stable in RESPOND while rsp_busy=1; no request is accepted until it is sent.
module bus_memory_controller #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int ID_W         = 4,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_busy,
    input  logic [1:0]        req_kind,
    input  logic [ID_W-1:0]   req_source,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_payload,
    output logic              req_accept,
    input  logic              rsp_busy,
    output logic              rsp_send,
    output logic [1:0]        rsp_kind,
    output logic [ID_W-1:0]   rsp_source,
    output logic [ADDR_W-1:0] rsp_address,
    output logic [DATA_W-1:0] rsp_payload,
    output logic [7:0]        err_count,
    output logic              idle
);
    localparam int         BYTE_SH  = $clog2(DATA_W / 8);
    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [1:0] KIND_RD  = 2'd0;
    localparam logic [1:0] KIND_WR  = 2'd1;
    localparam logic [1:0] KIND_RSP = 2'd2;

    typedef enum logic [1:0] {IDLE, READ_WAIT, RESPOND} state_t;

    state_t            state_q, state_d;
    logic              accepted_q, accepted_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ID_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              inr_q, inr_d;
    logic [1:0]        rsp_kind_q, rsp_kind_d;
    logic [ID_W-1:0]   rsp_source_q, rsp_source_d;
    logic [DATA_W-1:0] rsp_payload_q, rsp_payload_d;
    logic [7:0]        err_q, err_d;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [ADDR_W-1:0] req_word;
    logic              req_inr;
    logic              accept;
    logic              mem_we;
    logic              err_inc;

    // Byte address to word index; the low byte-lane bits are simply dropped.
    assign req_word = req_address >> BYTE_SH;
    assign req_inr  = (req_word < ADDR_W'(MEM_WORDS));

    // Next-state, request capture, response formation and error accounting.
    always_comb begin
        state_d       = state_q;
        accepted_d    = 1'b0;
        cnt_d         = cnt_q;
        src_d         = src_q;
        idx_d         = idx_q;
        inr_d         = inr_q;
        rsp_kind_d    = rsp_kind_q;
        rsp_source_d  = rsp_source_q;
        rsp_payload_d = rsp_payload_q;
        accept        = 1'b0;
        mem_we        = 1'b0;
        err_inc       = 1'b0;
        rsp_send      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // accepted_q masks the stale req_busy the bus still shows the cycle after an accept;
                // reset_n gating keeps the pulse (and any RAM write) quiet while reset is held.
                if (req_busy && !accepted_q && reset_n) begin
                    accept     = 1'b1;
                    accepted_d = 1'b1;
                    src_d      = req_source;
                    idx_d      = req_word[IDX_W-1:0];
                    inr_d      = req_inr;
                    case (req_kind)
                        KIND_RD: begin
                            cnt_d   = 4'(READ_LATENCY);
                            state_d = READ_WAIT;
                        end
                        KIND_WR: begin
                            mem_we  = req_inr;
                            err_inc = !req_inr;
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Data is captured on the edge where the count reaches zero.
                if (cnt_q == 4'd1) begin
                    rsp_payload_d = inr_q ? mem[idx_q] : '0;
                    err_inc       = !inr_q;
                    rsp_source_d  = src_q;
                    rsp_kind_d    = KIND_RSP;
                    state_d       = RESPOND;
                end
            end
            RESPOND: begin
                if (!rsp_busy) begin
                    rsp_send = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    // Control and response registers; reset abandons any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            accepted_q    <= 1'b0;
            cnt_q         <= '0;
            src_q         <= '0;
            idx_q         <= '0;
            inr_q         <= 1'b0;
            rsp_kind_q    <= '0;
            rsp_source_q  <= '0;
            rsp_payload_q <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            accepted_q    <= accepted_d;
            cnt_q         <= cnt_d;
            src_q         <= src_d;
            idx_q         <= idx_d;
            inr_q         <= inr_d;
            rsp_kind_q    <= rsp_kind_d;
            rsp_source_q  <= rsp_source_d;
            rsp_payload_q <= rsp_payload_d;
            err_q         <= err_d;
        end
    end

    // RAM write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_word[IDX_W-1:0]] <= req_payload;
        end
    end

    assign req_accept  = accept;
    assign rsp_kind    = rsp_kind_q;
    assign rsp_source  = rsp_source_q;
    assign rsp_address = '0;
    assign rsp_payload = rsp_payload_q;
    assign err_count   = err_q;
    assign idle        = (state_q == IDLE);
endmodule
